// File: rtl/uart_mult_engine.sv
// Two-byte UART multiplier: receives operand A then B, forms the 16-bit
// unsigned product by shift-add and transmits it high byte first.
module uart_mult_engine #(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        busy,
    output logic        overrun,
    output logic        timeout
);

    // state   | meaning
    // IDLE    | waiting for operand A
    // WAIT_B  | A held, counting idle cycles until operand B
    // MULT    | eight shift-add steps, one bit of B per cycle
    // SEND_HI | waiting for tx_ready to send result[15:8]
    // GAP_HI  | one cycle spacing after the high byte
    // SEND_LO | waiting for tx_ready to send result[7:0]
    // GAP_LO  | one cycle spacing after the low byte
    typedef enum logic [2:0] {
        IDLE, WAIT_B, MULT, SEND_HI, GAP_HI, SEND_LO, GAP_LO
    } state_t;

    state_t      state;
    logic [7:0]  a_reg;
    logic [7:0]  b_reg;
    logic [15:0] acc;
    logic [2:0]  bit_cnt;
    logic [15:0] wait_cnt;
    logic [15:0] addend;

    assign addend = b_reg[bit_cnt] ? ({8'd0, a_reg} << bit_cnt) : 16'd0;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            a_reg        <= 8'd0;
            b_reg        <= 8'd0;
            acc          <= 16'd0;
            bit_cnt      <= 3'd0;
            wait_cnt     <= 16'd0;
            tx_data      <= 8'd0;
            tx_start     <= 1'b0;
            result       <= 16'd0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            tx_start     <= 1'b0;
            result_valid <= 1'b0;

            // Any byte arriving outside the two operand-collecting states is dropped.
            if (rx_valid && state != IDLE && state != WAIT_B)
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        a_reg    <= rx_data;
                        wait_cnt <= 16'd0;
                        state    <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (rx_valid) begin
                        b_reg   <= rx_data;
                        acc     <= 16'd0;
                        bit_cnt <= 3'd0;
                        state   <= MULT;
                    end else if (wait_cnt == TIMEOUT - 16'd1) begin
                        timeout <= 1'b1;
                        a_reg   <= 8'd0;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                MULT: begin
                    acc     <= acc + addend;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        result       <= acc + addend;
                        result_valid <= 1'b1;
                        state        <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (tx_ready) begin
                        tx_data  <= result[15:8];
                        tx_start <= 1'b1;
                        state    <= GAP_HI;
                    end
                end
                GAP_HI: state <= SEND_LO;
                SEND_LO: begin
                    if (tx_ready) begin
                        tx_data  <= result[7:0];
                        tx_start <= 1'b1;
                        state    <= GAP_LO;
                    end
                end
                GAP_LO: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mult_engine.sv
// Directed bench for uart_mult_engine: products, tx framing, timeout,
// overrun with transmitter back-pressure, and reset mid-multiply.
module tb_uart_mult_engine;

    localparam logic [15:0] TMO = 16'd20;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic [15:0] result;
    logic        result_valid;
    logic        busy;
    logic        overrun;
    logic        timeout;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int rv_cyc  = 0;
    int rv_cnt  = 0;
    int tx_byte[$];
    int tx_cyc[$];
    int b_edge;

    uart_mult_engine #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_ready(tx_ready), .tx_data(tx_data), .tx_start(tx_start),
        .result(result), .result_valid(result_valid), .busy(busy),
        .overrun(overrun), .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_start) begin
            tx_byte.push_back(int'(tx_data));
            tx_cyc.push_back(cyc);
        end
        if (result_valid) begin
            rv_cyc = cyc;
            rv_cnt++;
        end
    end

    task automatic check(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_in_budget"}, int'(busy), 0);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp);
        tx_byte.delete();
        tx_cyc.delete();
        send_byte(a);
        send_byte(b);
        b_edge = cyc;
        wait_idle(tag, 200);
        check({tag, "_result"}, int'(result), int'(exp));
        check({tag, "_rv_latency"}, rv_cyc - b_edge, 8);
        check({tag, "_tx_count"}, tx_byte.size(), 2);
        if (tx_byte.size() == 2) begin
            check({tag, "_tx_hi"}, tx_byte[0], int'(exp[15:8]));
            check({tag, "_tx_lo"}, tx_byte[1], int'(exp[7:0]));
            check({tag, "_tx_first_after_rv"}, tx_cyc[0] - rv_cyc, 1);
            check({tag, "_tx_spacing"}, tx_cyc[1] - tx_cyc[0], 2);
        end
        check({tag, "_tx_data_hold"}, int'(tx_data), int'(exp[7:0]));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_data"}, int'(tx_data), 0);
        check({tag, "_tx_start"}, int'(tx_start), 0);
        check({tag, "_result"}, int'(result), 0);
        check({tag, "_result_valid"}, int'(result_valid), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
        check({tag, "_timeout"}, int'(timeout), 0);
    endtask

    initial begin
        int n;
        reset    = 1'b0;
        rx_data  = 8'd0;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        idle(3);
        check_all_zero("reset");
        reset = 1'b1;
        idle(2);

        run_op("mul_0c_0d", 8'h0C, 8'h0D, 16'h009C);
        run_op("mul_ff_ff", 8'hFF, 8'hFF, 16'hFE01);
        run_op("mul_00_37", 8'h00, 8'h37, 16'h0000);

        // Operand A with no B: must time out, drop A and send nothing.
        tx_byte.delete();
        send_byte(8'h05);
        idle(int'(TMO) - 3);
        check("tmo_not_yet", int'(timeout), 0);
        check("tmo_busy_waiting", int'(busy), 1);
        idle(5);
        check("tmo_flag", int'(timeout), 1);
        check("tmo_busy_cleared", int'(busy), 0);
        check("tmo_no_tx", tx_byte.size(), 0);
        run_op("mul_03_04", 8'h03, 8'h04, 16'h000C);
        check("tmo_sticky", int'(timeout), 1);

        // Stray byte during MULT plus a stalled transmitter.
        check("ovr_clear_before", int'(overrun), 0);
        tx_byte.delete();
        tx_cyc.delete();
        tx_ready = 1'b0;
        send_byte(8'h21);
        send_byte(8'h03);
        idle(2);
        send_byte(8'h55);
        n = 0;
        while (!result_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("ovr_rv_seen", int'(result_valid), 1);
        idle(100);
        check("ovr_flag", int'(overrun), 1);
        check("ovr_result", int'(result), 16'h0063);
        check("ovr_stall_no_tx", tx_byte.size(), 0);
        check("ovr_stall_busy", int'(busy), 1);
        tx_ready = 1'b1;
        wait_idle("ovr", 50);
        check("ovr_tx_count", tx_byte.size(), 2);
        if (tx_byte.size() == 2) begin
            check("ovr_tx_hi", tx_byte[0], 8'h00);
            check("ovr_tx_lo", tx_byte[1], 8'h63);
        end
        check("ovr_result_after", int'(result), 16'h0063);

        // Reset in the middle of the multiply.
        tx_byte.delete();
        send_byte(8'h11);
        send_byte(8'h22);
        idle(3);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("rst_mult");
        reset = 1'b1;
        idle(30);
        check("rst_no_tx", tx_byte.size(), 0);
        check("rst_stays_idle", int'(busy), 0);
        check("rst_no_rv", int'(result_valid), 0);
        run_op("mul_07_06", 8'h07, 8'h06, 16'h002A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
